// File: rtl/tm_spike_aer.sv
// Time-multiplexed LIF spike to AER event encoder with a {neuron, timestep} event FIFO.
// Optional dropped-event counter port enabled by defining TM_SPIKE_AER_DROP_CNT_EN.
module tm_spike_aer #(
  parameter int FIFO_DEPTH = 16,
  parameter int TSTEP_W    = 16
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               LIF_spike,
  input  logic               slot_valid,
  output logic               aer_valid,
  input  logic               aer_ready,
  output logic [9:0]         aer_addr,
  output logic [TSTEP_W-1:0] aer_tstep,
  output logic               overflow
`ifdef TM_SPIKE_AER_DROP_CNT_EN
  ,
  output logic [7:0]         drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 10 + TSTEP_W;
  localparam logic [AW:0]        PTR_ONE  = (AW+1)'(1);
  localparam logic [TSTEP_W-1:0] TS_ONE   = TSTEP_W'(1);
  localparam logic [9:0]         SLOT_ONE = 10'd1;
  localparam logic [9:0]         SLOT_MAX = 10'd1023;

  logic [9:0]         r_slot;
  logic [TSTEP_W-1:0] r_tstep;
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic [EW-1:0]      r_mem [FIFO_DEPTH];
  logic               r_overflow;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_wr_en;
  logic               w_drop;
  logic [EW-1:0]      w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = slot_valid & LIF_spike;
  assign w_pop   = ~w_empty & aer_ready;
  // A pop on a full FIFO frees the slot the incoming push lands in.
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign aer_valid = ~w_empty;
  assign aer_addr  = w_empty ? 10'd0 : w_head[EW-1 -: 10];
  assign aer_tstep = w_empty ? '0 : w_head[TSTEP_W-1:0];
  assign overflow  = r_overflow;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_slot  <= '0;
      r_tstep <= '0;
    end else if (slot_valid) begin
      r_slot <= r_slot + SLOT_ONE;
      if (r_slot == SLOT_MAX) begin
        r_tstep <= r_tstep + TS_ONE;
      end
    end
  end

  // Storage is left unreset so it maps onto RAM; the pointers alone define contents.
  always_ff @(posedge clk_in) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {r_slot, r_tstep};
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef TM_SPIKE_AER_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_tm_spike_aer.sv
// Directed bench for tm_spike_aer: frame/timestep tagging, slot holding, overflow, full-with-pop and reset.
module tb_tm_spike_aer;

  localparam int FIFO_DEPTH = 16;
  localparam int TSTEP_W    = 3;

  logic               clk_in = 1'b0;
  logic               reset;
  logic               LIF_spike;
  logic               slot_valid;
  logic               aer_valid;
  logic               aer_ready;
  logic [9:0]         aer_addr;
  logic [TSTEP_W-1:0] aer_tstep;
  logic               overflow;
`ifdef TM_SPIKE_AER_DROP_CNT_EN
  logic [7:0]         drop_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  tm_spike_aer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TSTEP_W   (TSTEP_W)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .LIF_spike (LIF_spike),
    .slot_valid(slot_valid),
    .aer_valid (aer_valid),
    .aer_ready (aer_ready),
    .aer_addr  (aer_addr),
    .aer_tstep (aer_tstep),
    .overflow  (overflow)
`ifdef TM_SPIKE_AER_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic sv, input logic sp, input logic rdy);
    slot_valid = sv;
    LIF_spike  = sp;
    aer_ready  = rdy;
    @(posedge clk_in);
    #1;
  endtask

  // One full frame of valid slots with aer_ready=1 and spikes at up to three indices.
  task automatic run_frame(input int a, input int b, input int c, input int ts);
    bit prev;
    bit sp;
    prev = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      sp = (i == a) || (i == b) || (i == c);
      cyc(1'b1, sp, 1'b1);
      if (sp) begin
        chk("ev_valid", 32'(aer_valid), 32'd1);
        chk("ev_addr",  32'(aer_addr),  32'(i));
        chk("ev_tstep", 32'(aer_tstep), 32'(ts));
      end else if (prev) begin
        chk("ev_popped", 32'(aer_valid), 32'd0);
      end
      prev = sp;
    end
  endtask

  initial begin
    reset      = 1'b1;
    LIF_spike  = 1'b0;
    slot_valid = 1'b0;
    aer_ready  = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("rst_valid",    32'(aer_valid), 32'd0);
    chk("rst_addr",     32'(aer_addr),  32'd0);
    chk("rst_tstep",    32'(aer_tstep), 32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
`ifdef TM_SPIKE_AER_DROP_CNT_EN
    chk("rst_drop_cnt", 32'(drop_cnt),  32'd0);
`endif
    reset = 1'b0;

    // ready with an empty FIFO must not disturb anything
    cyc(1'b0, 1'b0, 1'b1);
    chk("idle_ready", 32'(aer_valid), 32'd0);

    // Frame tagging and timestep wrap (TSTEP_W=3 wraps after 8 frames)
    run_frame(0, 5, 1023, 0);
    run_frame(2, -1, -1, 1);
    for (int ts = 2; ts < 7; ts++) run_frame(-1, -1, -1, ts);
    run_frame(3, -1, -1, 7);
    run_frame(1, -1, -1, 0);

    // slot_valid low mid-frame: slot index holds, spikes ignored
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      chk("gap_valid", 32'(aer_valid), 32'd0);
    end
    cyc(1'b1, 1'b1, 1'b1);
    chk("gap_addr",  32'(aer_addr),  32'd10);
    chk("gap_tstep", 32'(aer_tstep), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("gap_popped", 32'(aer_valid), 32'd0);

    // Overflow: 17 spikes into a 16-deep FIFO with no consumer
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    chk("full_head",   32'(aer_addr), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("ovf_flag",  32'(overflow),  32'd1);
    chk("ovf_valid", 32'(aer_valid), 32'd1);
    chk("ovf_head",  32'(aer_addr),  32'd0);
`ifdef TM_SPIKE_AER_DROP_CNT_EN
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    for (int k = 0; k < 16; k++) begin
      chk("drain1_addr", 32'(aer_addr), 32'(k));
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("drain1_empty", 32'(aer_valid), 32'd0);
    chk("ovf_sticky",   32'(overflow),  32'd1);

    // Full FIFO with a same-cycle pop: push accepted, new event last out
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("full2_head", 32'(aer_addr), 32'd17);
    cyc(1'b1, 1'b1, 1'b1);
`ifdef TM_SPIKE_AER_DROP_CNT_EN
    chk("fullpop_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    for (int k = 0; k < 16; k++) begin
      chk("drain2_addr", 32'(aer_addr), 32'(18 + k));
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("drain2_empty", 32'(aer_valid), 32'd0);

    // Reset with events queued discards them and restarts the slot counter
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("queued_valid", 32'(aer_valid), 32'd1);
    chk("queued_head",  32'(aer_addr),  32'd34);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    chk("rst2_valid",    32'(aer_valid), 32'd0);
    chk("rst2_overflow", 32'(overflow),  32'd0);
    chk("rst2_addr",     32'(aer_addr),  32'd0);
`ifdef TM_SPIKE_AER_DROP_CNT_EN
    chk("rst2_drop_cnt", 32'(drop_cnt),  32'd0);
`endif
    cyc(1'b1, 1'b1, 1'b0);
    chk("post_rst_valid", 32'(aer_valid), 32'd1);
    chk("post_rst_addr",  32'(aer_addr),  32'd0);
    chk("post_rst_tstep", 32'(aer_tstep), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
